// File: rtl/ir_alarm_ctrl.sv
// Multi-channel IR intrusion alarm: per-channel sync + debounce, alarm FSM, pulsed buzzer.
// Define IR_ALARM_LATCH_EN to keep the alarm in HOLD after the hold time expires.
module ir_alarm_ctrl #(
    parameter int N_CH        = 4,
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int BEEP_HALF   = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_CH-1:0] IR_IN,
    input  logic [N_CH-1:0] CH_EN,
    input  logic            ACK,
    output logic            BUZZER,
    output logic            ALARM,
    output logic [3:0]      ALARM_CH,
    output logic [7:0]      EVT_CNT
);

    localparam int DW = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BW = (BEEP_HALF   > 1) ? $clog2(BEEP_HALF)   : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALARM,
        S_HOLD,
        S_MUTED
    } state_t;

    logic [N_CH-1:0] sync1_q, sync2_q;
    logic [N_CH-1:0] deb_q, deb_d;
    logic [DW-1:0]   deb_cnt_q [N_CH];
    logic [DW-1:0]   deb_cnt_d [N_CH];

    state_t          state_q, state_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [BW-1:0]   beep_cnt_q, beep_cnt_d;
    logic            beep_on_q, beep_on_d;
    logic [3:0]      alarm_ch_q, alarm_ch_d;
    logic [7:0]      evt_cnt_q, evt_cnt_d;

    logic [N_CH-1:0] armed;
    logic            detect;
    logic [3:0]      first_ch;

    // NOTE: every register is updated with <=, so all flops sample pre-edge values
    // regardless of statement order; blocking = is reserved for combinational blocks.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= IR_IN;
            sync2_q <= sync1_q;
        end
    end

    // A channel's level flips only after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches inferred.
        deb_d = deb_q;
        for (int i = 0; i < N_CH; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1))
                    deb_d[i] = sync2_q[i];
                else
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            deb_q <= '0;
            // NOTE: the counter array is tiny and must restart from zero, so each
            // element is reset explicitly (unlike RAM-style storage, which is not).
            for (int i = 0; i < N_CH; i++)
                deb_cnt_q[i] <= '0;
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < N_CH; i++)
                deb_cnt_q[i] <= deb_cnt_d[i];
        end
    end

    assign armed  = deb_q & CH_EN;
    assign detect = |armed;

    // Lowest-index armed channel wins; scanning downward leaves the lowest hit last.
    always_comb begin
        first_ch = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (armed[i])
                first_ch = 4'(i);
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        beep_cnt_d = beep_cnt_q;
        beep_on_d  = beep_on_q;
        alarm_ch_d = alarm_ch_q;
        evt_cnt_d  = evt_cnt_q;

        if (state_q == S_ALARM || state_q == S_HOLD) begin
            if (beep_cnt_q == BW'(BEEP_HALF - 1)) begin
                beep_cnt_d = '0;
                beep_on_d  = ~beep_on_q;
            end else begin
                beep_cnt_d = beep_cnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (detect) begin
                    state_d    = S_ALARM;
                    alarm_ch_d = first_ch;
                    beep_cnt_d = '0;
                    beep_on_d  = 1'b1;
                    if (evt_cnt_q != 8'hFF)
                        evt_cnt_d = evt_cnt_q + 8'd1;
                end
            end
            S_ALARM: begin
                if (ACK) begin
                    state_d = S_MUTED;
                end else if (!detect) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = HW'(HOLD_CYCLES - 1);
                end
            end
            S_HOLD: begin
                if (ACK) begin
                    state_d = S_MUTED;
                end else if (detect) begin
                    state_d = S_ALARM;
                end else if (hold_cnt_q == '0) begin
`ifdef IR_ALARM_LATCH_EN
                    state_d = S_HOLD;
`else
                    state_d = S_IDLE;
`endif
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            S_MUTED: begin
                if (!detect)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
            beep_cnt_q <= '0;
            beep_on_q  <= 1'b0;
            alarm_ch_q <= '0;
            evt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            beep_cnt_q <= beep_cnt_d;
            beep_on_q  <= beep_on_d;
            alarm_ch_q <= alarm_ch_d;
            evt_cnt_q  <= evt_cnt_d;
        end
    end

    assign ALARM    = (state_q != S_IDLE);
    assign BUZZER   = (state_q == S_ALARM || state_q == S_HOLD) && beep_on_q;
    assign ALARM_CH = alarm_ch_q;
    assign EVT_CNT  = evt_cnt_q;

endmodule

// File: tb/tb_ir_alarm_ctrl.sv
// Directed bench for ir_alarm_ctrl at N_CH=4, DEB_CYCLES=4, HOLD_CYCLES=16, BEEP_HALF=8.
// Expected values are hand-derived edge counts; honours IR_ALARM_LATCH_EN when defined.
module tb_ir_alarm_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] IR_IN;
    logic [3:0] CH_EN;
    logic       ACK;
    logic       BUZZER;
    logic       ALARM;
    logic [3:0] ALARM_CH;
    logic [7:0] EVT_CNT;

    int n_checks = 0;
    int n_fail   = 0;

    ir_alarm_ctrl #(
        .N_CH(4), .DEB_CYCLES(4), .HOLD_CYCLES(16), .BEEP_HALF(8)
    ) dut (
        .CLK(CLK), .RST(RST), .IR_IN(IR_IN), .CH_EN(CH_EN), .ACK(ACK),
        .BUZZER(BUZZER), .ALARM(ALARM), .ALARM_CH(ALARM_CH), .EVT_CNT(EVT_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
    endtask

    task automatic one_alarm_acked();
        IR_IN = 4'b0001;
        tick(7);
        ACK = 1'b1;
        tick();
        ACK   = 1'b0;
        IR_IN = 4'b0000;
        tick(8);
    endtask

    initial begin
        RST = 1'b1; IR_IN = '0; CH_EN = 4'hF; ACK = 1'b0;
        #1;
        check("rst_alarm",  ALARM,    0);
        check("rst_buzzer", BUZZER,   0);
        check("rst_ch",     ALARM_CH, 0);
        check("rst_evt",    EVT_CNT,  0);
        do_reset();

        // Single channel 2: latency and buzzer cadence
        IR_IN = 4'b0100;
        tick(6);
        check("lat_edge6_alarm", ALARM, 0);
        tick();
        check("lat_edge7_alarm",  ALARM,    1);
        check("lat_edge7_buzzer", BUZZER,   1);
        check("lat_ch",           ALARM_CH, 2);
        check("lat_evt",          EVT_CNT,  1);
        tick(7);
        check("beep_edge14_on",  BUZZER, 1);
        tick();
        check("beep_edge15_off", BUZZER, 0);
        tick(7);
        check("beep_edge22_off", BUZZER, 0);
        tick();
        check("beep_edge23_on",  BUZZER, 1);

        // 3-cycle glitch is rejected; 4-cycle pulse is accepted
        do_reset();
        IR_IN = 4'b0001;
        tick(3);
        IR_IN = 4'b0000;
        tick(15);
        check("glitch_alarm", ALARM,   0);
        check("glitch_evt",   EVT_CNT, 0);
        IR_IN = 4'b0001;
        tick(4);
        IR_IN = 4'b0000;
        tick(3);
        check("pulse4_alarm", ALARM,    1);
        check("pulse4_evt",   EVT_CNT,  1);
        check("pulse4_ch",    ALARM_CH, 0);

        // Channel enable mask acts combinationally
        do_reset();
        CH_EN = 4'b1110;
        IR_IN = 4'b0001;
        tick(10);
        check("mask_alarm", ALARM, 0);
        CH_EN = 4'hF;
        tick();
        check("unmask_alarm", ALARM,    1);
        check("unmask_ch",    ALARM_CH, 0);

        // Two channels together, later channel ignored, then hold timing
        do_reset();
        IR_IN = 4'b1010;
        tick(7);
        check("multi_alarm", ALARM,    1);
        check("multi_ch",    ALARM_CH, 1);
        IR_IN = 4'b1011;
        tick(10);
        check("multi_ch_kept", ALARM_CH, 1);
        check("multi_evt",     EVT_CNT,  1);
        IR_IN = 4'b0000;
        tick(6);
        check("fall_edge6_alarm", ALARM, 1);
        tick(16);
        check("hold_edge22_alarm", ALARM, 1);
        tick();
`ifdef IR_ALARM_LATCH_EN
        check("latch_edge23_alarm", ALARM, 1);
        tick(20);
        check("latch_persist_alarm", ALARM, 1);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        check("latch_ack_alarm",  ALARM,  1);
        check("latch_ack_buzzer", BUZZER, 0);
        tick();
        check("latch_idle_alarm", ALARM, 0);
`else
        check("hold_edge23_alarm",  ALARM,  0);
        check("hold_edge23_buzzer", BUZZER, 0);
`endif

        // ACK mutes while input held; release returns to IDLE without a new event
        do_reset();
        IR_IN = 4'b0100;
        tick(7);
        check("ack_pre_alarm", ALARM, 1);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        check("mute_buzzer", BUZZER, 0);
        check("mute_alarm",  ALARM,  1);
        ACK = 1'b1;
        tick(3);
        ACK = 1'b0;
        check("mute_ack_ignored", ALARM,  1);
        check("mute_buzzer2",     BUZZER, 0);
        IR_IN = 4'b0000;
        tick(6);
        check("mute_edge6_alarm", ALARM, 1);
        tick();
        check("mute_edge7_alarm", ALARM,   0);
        check("mute_evt",         EVT_CNT, 1);

        // Input returns during HOLD: back to ALARM, no new event
        do_reset();
        IR_IN = 4'b0100;
        tick(7);
        IR_IN = 4'b0000;
        tick(9);
        IR_IN = 4'b0100;
        tick(7);
        check("rearm_alarm", ALARM,    1);
        check("rearm_evt",   EVT_CNT,  1);
        check("rearm_ch",    ALARM_CH, 2);
        tick(20);
        check("rearm_held_alarm", ALARM, 1);

        // Event counter saturation
        do_reset();
        for (int i = 0; i < 255; i++) begin
            one_alarm_acked();
            if (i == 0)
                check("evt_first", EVT_CNT, 1);
        end
        check("evt_255", EVT_CNT, 255);
        one_alarm_acked();
        check("evt_sat", EVT_CNT, 255);

        // Reset mid-alarm clears outputs immediately, held input re-triggers
        do_reset();
        IR_IN = 4'b0100;
        tick(7);
        check("pre_rst_alarm", ALARM, 1);
        RST = 1'b1;
        #1;
        check("midrst_alarm",  ALARM,    0);
        check("midrst_buzzer", BUZZER,   0);
        check("midrst_ch",     ALARM_CH, 0);
        check("midrst_evt",    EVT_CNT,  0);
        tick(2);
        RST = 1'b0;
        tick(6);
        check("retrig_edge6_alarm", ALARM, 0);
        tick();
        check("retrig_edge7_alarm", ALARM,   1);
        check("retrig_evt",         EVT_CNT, 1);
        check("retrig_ch",          ALARM_CH, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ir_alarm_ctrl.md
IR_ALARM_CTRL -- requirements
Module: ir_alarm_ctrl

Interface
REQ-001 Parameter N_CH, 4, number of IR sensor channels, legal 1..16.
REQ-002 Parameter DEB_CYCLES, 4, consecutive stable cycles required to accept a channel change, legal >=1.
REQ-003 Parameter HOLD_CYCLES, 16, alarm hold time after detection clears, legal >=1.
REQ-004 Parameter BEEP_HALF, 8, buzzer on-time and off-time in cycles, legal >=1.
REQ-005 CLK  input  1  clock; all state updates on rising edge.
REQ-006 RST  input  1  reset, asynchronous, active-high.
REQ-007 IR_IN  input  N_CH  raw asynchronous sensor levels; 1 = object detected.
REQ-008 CH_EN  input  N_CH  channel enable mask; 1 = channel armed.
REQ-009 ACK  input  1  operator silence, sampled per cycle.
REQ-010 BUZZER  output  1  pulsed buzzer drive.
REQ-011 ALARM  output  1  alarm active (ALARM, HOLD or MUTED state).
REQ-012 ALARM_CH  output  4  index of the channel that triggered the current alarm.
REQ-013 EVT_CNT  output  8  count of IDLE->ALARM entries, saturating at 255.

Function
REQ-014 Each IR_IN bit SHALL pass a two-flop synchroniser before any other use.
REQ-015 Each channel SHALL keep a debounced level; it flips only when the synchronised level differs from it for DEB_CYCLES consecutive cycles; any agreeing cycle clears that channel's counter.
REQ-016 detect SHALL be the OR of (debounced & CH_EN), combinational; CH_EN takes effect the same cycle.
REQ-017 FSM states SHALL be IDLE, ALARM, HOLD, MUTED, all registered.
REQ-018 IDLE: detect -> ALARM; same edge latches ALARM_CH = lowest-index set bit of (debounced & CH_EN) and increments EVT_CNT (holds at 255).
REQ-019 ALARM: detect low -> HOLD with hold counter loaded to HOLD_CYCLES-1; ACK -> MUTED; ACK takes priority over detect falling.
REQ-020 HOLD: detect high -> ALARM, with no EVT_CNT increment and ALARM_CH unchanged; ACK -> MUTED; otherwise counter decrements, and at 0 the FSM goes to IDLE (see REQ-029).
REQ-021 MUTED: BUZZER 0, ALARM 1; detect low -> IDLE; ACK ignored.
REQ-022 BUZZER in ALARM/HOLD SHALL be 1 for BEEP_HALF cycles then 0 for BEEP_HALF cycles, repeating; the phase counter restarts on-phase on every IDLE->ALARM entry and continues across ALARM<->HOLD; BUZZER 0 in IDLE and MUTED.
REQ-023 Latency: with IR_IN rising stable before edge 1 and CH_EN set, ALARM and BUZZER SHALL first read 1 after edge DEB_CYCLES+3.
REQ-024 A stable IR_IN fall SHALL enter HOLD after edge DEB_CYCLES+3 from the first edge sampling low; glitches shorter than DEB_CYCLES cycles SHALL not change state.
REQ-025 Simultaneous multi-channel detection SHALL report the lowest index; later channels never overwrite ALARM_CH during one alarm.

Reset
REQ-026 RST high SHALL immediately force IDLE, with BUZZER=0, ALARM=0, ALARM_CH=0, EVT_CNT=0, and clear all synchroniser, debounce and hold counters and debounced levels.
REQ-027 After RST releases mid-alarm, an input still held high SHALL re-trigger per REQ-023 and count as a new event.

Configuration
REQ-028 Macro IR_ALARM_LATCH_EN SHALL select latching behaviour.
REQ-029 Without it: hold counter at 0 in HOLD -> IDLE. With it: HOLD expiry does not leave HOLD and BUZZER keeps pulsing; only ACK (-> MUTED) or detect (-> ALARM) leaves HOLD.

Verification (N_CH=4, DEB_CYCLES=4, HOLD_CYCLES=16, BEEP_HALF=8)
REQ-030 IR_IN=4'b0100, CH_EN=4'hF -> ALARM=1 after edge 7, ALARM_CH=2, EVT_CNT=1, BUZZER 8 high / 8 low.
REQ-031 IR_IN bit0 pulses high for 3 cycles -> ALARM stays 0 and EVT_CNT stays 0.
REQ-032 IR_IN=4'b1010 asserted together -> ALARM_CH=1; IR_IN cleared -> HOLD for 16 cycles -> IDLE (macro off) or HOLD persists until ACK (macro on).
REQ-033 ACK during ALARM with input held -> BUZZER 0, ALARM 1; input released -> IDLE after debounce, no EVT_CNT change.
REQ-034 Input returns during HOLD -> ALARM without EVT_CNT increment; 256 separate alarms -> EVT_CNT=255; RST mid-alarm -> all outputs 0 immediately.
